// File: rtl/sdram_arbit.sv
// sdram_arbit: central arbiter and command multiplexer for the SDRAM controller.
// It holds the bus for the init sequence until init_end. After that it grants
// one requester at a time. Refresh has top priority, and write/read alternate
// when both are pending. It has no preemption: a grant is held until the
// owner's end pulse.
module sdram_arbit #(
    parameter logic [3:0] CMD_NOP = 4'b0111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_end,
    input  logic [3:0]  init_cmd,
    input  logic [1:0]  init_bank_addr,
    input  logic [12:0] init_addr,
    input  logic        aref_req,
    input  logic        aref_end,
    input  logic [3:0]  aref_cmd,
    input  logic [12:0] aref_addr,
    input  logic [1:0]  aref_bank_addr,
    input  logic        wr_req,
    input  logic        wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [1:0]  wr_bank_addr,
    input  logic [12:0] wr_sdram_addr,
    input  logic        wr_sdram_en,
    input  logic [15:0] wr_sdram_data,
    input  logic        rd_req,
    input  logic        rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [1:0]  rd_bank_addr,
    input  logic [12:0] rd_sdram_addr,
    output logic        aref_en,
    output logic        wr_en,
    output logic        rd_en,
    output logic [3:0]  sdram_cmd,
    output logic [1:0]  sdram_bank_addr,
    output logic [12:0] sdram_addr,
    output logic        sdram_dq_oe,
    output logic [15:0] sdram_dq_out
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARBIT = 3'd1,
        AREF  = 3'd2,
        WRITE = 3'd3,
        READ  = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic   last_wr_q, last_wr_d;

    // State register and write/read fairness bit; reset takes effect at once, even mid-burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
        end
    end

    // Next-state: arbitration only happens in ARBIT, so every grant is separated by one ARBIT cycle
    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        case (state_q)
            IDLE: begin
                if (init_end) state_d = ARBIT;
            end
            ARBIT: begin
                if (aref_req) begin
                    state_d = AREF;
                end else if (wr_req && (!rd_req || !last_wr_q)) begin
                    // Write wins when it is alone, or under contention when read went last
                    state_d   = WRITE;
                    last_wr_d = 1'b1;
                end else if (rd_req) begin
                    state_d   = READ;
                    last_wr_d = 1'b0;
                end
            end
            AREF: begin
                if (aref_end) state_d = ARBIT;
            end
            WRITE: begin
                if (wr_end) state_d = ARBIT;
            end
            READ: begin
                if (rd_end) state_d = ARBIT;
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant decode and command/address mux, purely from the current state
    always_comb begin
        aref_en         = 1'b0;
        wr_en           = 1'b0;
        rd_en           = 1'b0;
        sdram_cmd       = CMD_NOP;
        sdram_bank_addr = 2'd0;
        sdram_addr      = 13'd0;
        case (state_q)
            IDLE: begin
                sdram_cmd       = init_cmd;
                sdram_bank_addr = init_bank_addr;
                sdram_addr      = init_addr;
            end
            AREF: begin
                aref_en         = 1'b1;
                sdram_cmd       = aref_cmd;
                sdram_bank_addr = aref_bank_addr;
                sdram_addr      = aref_addr;
            end
            WRITE: begin
                wr_en           = 1'b1;
                sdram_cmd       = wr_cmd;
                sdram_bank_addr = wr_bank_addr;
                sdram_addr      = wr_sdram_addr;
            end
            READ: begin
                rd_en           = 1'b1;
                sdram_cmd       = rd_cmd;
                sdram_bank_addr = rd_bank_addr;
                sdram_addr      = rd_sdram_addr;
            end
            default: ;
        endcase
    end

    // DQ is driven only while the write module owns the bus and flags valid data
    always_comb begin
        sdram_dq_oe  = (state_q == WRITE) && wr_sdram_en;
        sdram_dq_out = sdram_dq_oe ? wr_sdram_data : 16'h0000;
    end

endmodule

// File: tb/tb_sdram_arbit.sv
// tb_sdram_arbit: checks for sdram_arbit. The bench has four parts:
// a reset/init hold phase, a table of hand-derived cycle vectors,
// a reset-during-READ sequence, and a randomized run compared against
// a requester-level model.
module tb_sdram_arbit;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] INI = 4'b0010;
    localparam logic [3:0] ARC = 4'b0001;
    localparam logic [3:0] WRC = 4'b0100;
    localparam logic [3:0] RDC = 4'b0101;

    logic        clk, rst_n;
    logic        init_end;
    logic [3:0]  init_cmd;
    logic [1:0]  init_bank_addr;
    logic [12:0] init_addr;
    logic        aref_req, aref_end;
    logic [3:0]  aref_cmd;
    logic [12:0] aref_addr;
    logic [1:0]  aref_bank_addr;
    logic        wr_req, wr_end;
    logic [3:0]  wr_cmd;
    logic [1:0]  wr_bank_addr;
    logic [12:0] wr_sdram_addr;
    logic        wr_sdram_en;
    logic [15:0] wr_sdram_data;
    logic        rd_req, rd_end;
    logic [3:0]  rd_cmd;
    logic [1:0]  rd_bank_addr;
    logic [12:0] rd_sdram_addr;
    logic        aref_en, wr_en, rd_en;
    logic [3:0]  sdram_cmd;
    logic [1:0]  sdram_bank_addr;
    logic [12:0] sdram_addr;
    logic        sdram_dq_oe;
    logic [15:0] sdram_dq_out;

    int total = 0;
    int bad   = 0;

    sdram_arbit #(.CMD_NOP(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .init_end(init_end),
        .init_cmd(init_cmd), .init_bank_addr(init_bank_addr), .init_addr(init_addr),
        .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd),
        .aref_addr(aref_addr), .aref_bank_addr(aref_bank_addr),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_bank_addr(wr_bank_addr),
        .wr_sdram_addr(wr_sdram_addr), .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_bank_addr(rd_bank_addr),
        .rd_sdram_addr(rd_sdram_addr),
        .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
        .sdram_cmd(sdram_cmd), .sdram_bank_addr(sdram_bank_addr), .sdram_addr(sdram_addr),
        .sdram_dq_oe(sdram_dq_oe), .sdram_dq_out(sdram_dq_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model in requester terms: who holds the bus (-1 none, 0 refresh,
    // 1 write, 2 read), whether init has finished, and whether read goes next on a tie.
    bit m_init_done;
    int m_holder;
    bit m_read_next;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_init_done <= 1'b0;
            m_holder    <= -1;
            m_read_next <= 1'b0;
        end else if (!m_init_done) begin
            if (init_end) m_init_done <= 1'b1;
        end else if (m_holder < 0) begin
            if (aref_req) begin
                m_holder <= 0;
            end else if (wr_req && (!rd_req || !m_read_next)) begin
                m_holder    <= 1;
                m_read_next <= 1'b1;
            end else if (rd_req) begin
                m_holder    <= 2;
                m_read_next <= 1'b0;
            end
        end else if ((m_holder == 0 && aref_end) || (m_holder == 1 && wr_end) ||
                     (m_holder == 2 && rd_end)) begin
            m_holder <= -1;
        end
    end

    function automatic logic [38:0] model_out();
        logic [2:0]  g;
        logic [3:0]  c;
        logic [1:0]  b;
        logic [12:0] a;
        logic        oe;
        g = 3'b000; c = NOP; b = 2'd0; a = 13'd0;
        if (!m_init_done) begin
            c = init_cmd; b = init_bank_addr; a = init_addr;
        end else if (m_holder == 0) begin
            g = 3'b100; c = aref_cmd; b = aref_bank_addr; a = aref_addr;
        end else if (m_holder == 1) begin
            g = 3'b010; c = wr_cmd; b = wr_bank_addr; a = wr_sdram_addr;
        end else if (m_holder == 2) begin
            g = 3'b001; c = rd_cmd; b = rd_bank_addr; a = rd_sdram_addr;
        end
        oe = m_init_done && (m_holder == 1) && wr_sdram_en;
        return {g, c, b, a, oe, (oe ? wr_sdram_data : 16'h0000)};
    endfunction

    function automatic logic [38:0] dut_out();
        return {aref_en, wr_en, rd_en, sdram_cmd, sdram_bank_addr, sdram_addr,
                sdram_dq_oe, sdram_dq_out};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Control inputs packed as {init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end}
    task automatic set_ctl(input logic [6:0] v);
        {init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end} = v;
    endtask

    typedef struct packed {
        logic [6:0] ctl;
        logic [2:0] g;    // {aref_en, wr_en, rd_en} after the edge
        logic [3:0] cmd;  // sdram_cmd after the edge
    } vec_t;

    function automatic vec_t mkv(input logic [6:0] ctl, input logic [2:0] g, input logic [3:0] cmd);
        vec_t v;
        v.ctl = ctl; v.g = g; v.cmd = cmd;
        return v;
    endfunction

    task automatic randomize_data();
        init_cmd       = 4'($urandom);
        init_bank_addr = 2'($urandom);
        init_addr      = 13'($urandom);
        aref_cmd       = 4'($urandom);
        aref_bank_addr = 2'($urandom);
        aref_addr      = 13'($urandom);
        wr_cmd         = 4'($urandom);
        wr_bank_addr   = 2'($urandom);
        wr_sdram_addr  = 13'($urandom);
        wr_sdram_en    = 1'($urandom);
        wr_sdram_data  = 16'($urandom);
        rd_cmd         = 4'($urandom);
        rd_bank_addr   = 2'($urandom);
        rd_sdram_addr  = 13'($urandom);
    endtask

    vec_t vecs[24];

    initial begin
        vecs[0]  = mkv(7'b0000000, 3'b000, INI);
        vecs[1]  = mkv(7'b0001000, 3'b000, INI);
        vecs[2]  = mkv(7'b1001000, 3'b000, NOP);  // init done: one ARBIT cycle first
        vecs[3]  = mkv(7'b1001000, 3'b010, WRC);
        vecs[4]  = mkv(7'b1001000, 3'b010, WRC);
        vecs[5]  = mkv(7'b1001100, 3'b000, NOP);  // wr_end drops the grant
        vecs[6]  = mkv(7'b1000000, 3'b000, NOP);
        vecs[7]  = mkv(7'b1101010, 3'b100, ARC);  // all three pending: refresh wins
        vecs[8]  = mkv(7'b1101010, 3'b100, ARC);
        vecs[9]  = mkv(7'b1011010, 3'b000, NOP);
        vecs[10] = mkv(7'b1001010, 3'b001, RDC);  // write went last, so read
        vecs[11] = mkv(7'b1001010, 3'b001, RDC);
        vecs[12] = mkv(7'b1001011, 3'b000, NOP);
        vecs[13] = mkv(7'b1001010, 3'b010, WRC);  // read went last, so write
        vecs[14] = mkv(7'b1101010, 3'b010, WRC);  // refresh waits for wr_end
        vecs[15] = mkv(7'b1101011, 3'b010, WRC);  // stray rd_end ignored
        vecs[16] = mkv(7'b1101110, 3'b000, NOP);
        vecs[17] = mkv(7'b1101010, 3'b100, ARC);  // refresh beats pending read
        vecs[18] = mkv(7'b1011010, 3'b000, NOP);
        vecs[19] = mkv(7'b1001010, 3'b001, RDC);
        vecs[20] = mkv(7'b1010110, 3'b001, RDC);  // stray aref_end/wr_end ignored
        vecs[21] = mkv(7'b1000001, 3'b000, NOP);
        vecs[22] = mkv(7'b0000000, 3'b000, NOP);  // init_end low no longer matters
        vecs[23] = mkv(7'b0000010, 3'b001, RDC);

        // Reset state
        rst_n = 1'b0;
        set_ctl(7'b0000000);
        randomize_data();
        init_cmd = INI;
        #12;
        chk("reset_state", {aref_en, wr_en, rd_en, sdram_dq_oe, sdram_dq_out, sdram_cmd},
            {3'b000, 1'b0, 16'h0000, INI});
        #1 rst_n = 1'b1;

        // Init hold: requests ignored, bus follows init_* every cycle
        for (int i = 0; i < 200; i++) begin
            randomize_data();
            {aref_req, aref_end, wr_req, wr_end, rd_req, rd_end} = 6'($urandom);
            tick();
            chk($sformatf("init_hold[%0d]", i),
                {aref_en, wr_en, rd_en, sdram_cmd, sdram_bank_addr, sdram_addr, sdram_dq_oe, sdram_dq_out},
                {3'b000, init_cmd, init_bank_addr, init_addr, 1'b0, 16'h0000});
        end

        // Table-driven sequence
        init_cmd = INI; aref_cmd = ARC; wr_cmd = WRC; rd_cmd = RDC;
        wr_sdram_en = 1'b1; wr_sdram_data = 16'hA5C3;
        for (int i = 0; i < 24; i++) begin
            set_ctl(vecs[i].ctl);
            tick();
            chk($sformatf("vec[%0d]", i),
                {aref_en, wr_en, rd_en, sdram_cmd, sdram_dq_oe, sdram_dq_out},
                {vecs[i].g, vecs[i].cmd, vecs[i].g[1], (vecs[i].g[1] ? 16'hA5C3 : 16'h0000)});
        end

        // Reset in the middle of a READ grant, then restart with init_end already high
        set_ctl(7'b1000010);
        #2 rst_n = 1'b0;
        #1 chk("rst_during_read", {aref_en, wr_en, rd_en, sdram_dq_oe, sdram_cmd},
               {3'b000, 1'b0, INI});
        #1 rst_n = 1'b1;
        tick();
        chk("post_rst_arbit", {aref_en, wr_en, rd_en, sdram_cmd}, {3'b000, NOP});
        tick();
        chk("post_rst_grant", {aref_en, wr_en, rd_en, sdram_cmd}, {3'b001, RDC});

        // Randomized run against the model, with occasional asynchronous resets
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            randomize_data();
            init_end = ($urandom_range(0, 3) != 0);
            aref_req = ($urandom_range(0, 5) == 0);
            wr_req   = ($urandom_range(0, 2) != 0);
            rd_req   = ($urandom_range(0, 2) != 0);
            aref_end = ($urandom_range(0, 3) == 0);
            wr_end   = ($urandom_range(0, 3) == 0);
            rd_end   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) begin
                #2 rst_n = 1'b0;
                #1 chk($sformatf("rand_rst[%0d]", i), 64'(dut_out()), 64'(model_out()));
                #1 rst_n = 1'b1;
            end
            tick();
            chk($sformatf("rand[%0d]", i), 64'(dut_out()), 64'(model_out()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_arbit.md
Name: sdram_arbit

Overview:
Central arbiter and command multiplexer for the SDRAM controller. It sequences the init, auto-refresh, write and read sub-modules onto the single SDRAM command/address/data bus. It holds off all traffic until init completes. After that it grants one requester at a time: refresh always wins, and write/read alternate under contention. It sits between the sub-modules and the SDRAM pins, and it replaces the ad-hoc init/write mux used in the write-module bench.

Parameters:
CMD_NOP, 4'b0111, command driven on {CS_n,RAS_n,CAS_n,WE_n} while no requester owns the bus

Ports:
clk  in  1  100 MHz controller clock (clk_100M)
rst_n  in  1  asynchronous active-low reset (locked_rst_n at top)
init_end  in  1  level, high once the init sequence is complete
init_cmd  in  4  init command
init_bank_addr  in  2  init bank address
init_addr  in  13  init address
aref_req  in  1  level, refresh due
aref_end  in  1  1-cycle pulse, refresh done
aref_cmd  in  4  refresh command
aref_addr  in  13  refresh address
aref_bank_addr  in  2  refresh bank address
wr_req  in  1  level, write pending
wr_end  in  1  1-cycle pulse, burst done
wr_cmd  in  4  write command
wr_bank_addr  in  2  write bank address
wr_sdram_addr  in  13  write address
wr_sdram_en  in  1  write data valid on bus
wr_sdram_data  in  16  write data
rd_req  in  1  level, read pending
rd_end  in  1  1-cycle pulse, burst done
rd_cmd  in  4  read command
rd_bank_addr  in  2  read bank address
rd_sdram_addr  in  13  read address
aref_en  out  1  grant to refresh module
wr_en  out  1  grant to write module
rd_en  out  1  grant to read module
sdram_cmd  out  4  {CS_n,RAS_n,CAS_n,WE_n} to SDRAM
sdram_bank_addr  out  2  SDRAM bank address
sdram_addr  out  13  SDRAM address
sdram_dq_oe  out  1  tristate enable for DQ; the top drives DQ only when this is high
sdram_dq_out  out  16  DQ drive value

Behaviour:
- State register: IDLE, ARBIT, AREF, WRITE, READ.
- Extra register: last_wr (1 bit), set to 1 when WRITE is granted and cleared to 0 when READ is granted.
- Reset: state=IDLE, last_wr=0. Reset acts immediately, including mid-burst.
- Transitions:
  - IDLE->ARBIT on the first clk edge at which init_end=1; otherwise stay in IDLE.
  - ARBIT: if aref_req, go to AREF.
  - ARBIT: else if wr_req & rd_req, go to READ when last_wr=1, else WRITE.
  - ARBIT: else if wr_req, go to WRITE; else if rd_req, go to READ; else stay in ARBIT.
  - AREF->ARBIT on aref_end; WRITE->ARBIT on wr_end; READ->ARBIT on rd_end.
  - No preemption: aref_req arriving during WRITE/READ waits until that end pulse.
  - End pulses that arrive in a non-matching state are ignored.
  - After IDLE is left, init_end is ignored; only reset returns the block to IDLE.
- Grants are decoded combinationally from the state register: aref_en=(state==AREF), wr_en=(state==WRITE), rd_en=(state==READ). At most one grant is high in any cycle. Grant latency is 1 cycle from the request being sampled in ARBIT.
- A grant drops in the cycle after its end pulse, and ARBIT lasts at least 1 cycle between any two grants.
- Bus mux (combinational on state):
  - IDLE: init_* signals.
  - AREF: aref_*.
  - WRITE: wr_*.
  - READ: rd_*.
  - ARBIT: sdram_cmd=CMD_NOP, bank=0, addr=0.
- DQ: sdram_dq_oe = (state==WRITE) & wr_sdram_en. sdram_dq_out = wr_sdram_data when oe=1, else 16'h0.
- Reset output values (state=IDLE): all grants=0, sdram_dq_oe=0, sdram_dq_out=0; sdram_cmd/bank/addr follow init_*.

Test Plan:
- Reset, init_end low for 200 cycles -> state IDLE; bus equals init_* every cycle; all grants 0; dq_oe 0.
- init_end rises, wr_req=1 held -> ARBIT for 1 cycle, then wr_en=1 from the next edge. wr_end pulse -> wr_en=0 the following cycle, sdram_cmd=4'b0111. dq_oe tracks wr_sdram_en only during the grant.
- aref_req, wr_req and rd_req all asserted in ARBIT -> aref_en first. After aref_end, write is granted (last_wr=0). After wr_end, read is granted. The next contention grants write.
- aref_req asserted mid write burst -> wr_en stays high until wr_end. The next grant is aref_en, even with rd_req high.
- rst_n pulled low during READ -> rd_en=0 and dq_oe=0 immediately. After release with init_end=1, state passes through IDLE and then ARBIT before any grant.
- Spurious rd_end pulse during WRITE -> ignored; wr_en remains high.
